// File: rtl/arb8_encoder_ctrl.sv
// Eight-way round-robin arbiter with registered one-hot grant and 3-bit encoded index.
// Optional forced release after MAX_HOLD grant cycles when ARB_TIMEOUT_EN is defined.
module arb8_encoder_ctrl #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("MAX_HOLD must be in 2..255");
  end

  state_t     r_state, w_nxt_state;
  logic [2:0] r_ptr, w_nxt_ptr;
  logic [2:0] r_cur_id, w_nxt_cur_id;
  logic [7:0] r_gnt, w_nxt_gnt;
  logic [2:0] r_gnt_id, w_nxt_gnt_id;
  logic       r_gnt_valid, w_nxt_gnt_valid;
  logic       w_found;
  logic [2:0] w_sel;
`ifdef ARB_TIMEOUT_EN
  logic [7:0] r_hold_cnt, w_nxt_hold_cnt;
  logic       r_timeout, w_nxt_timeout;
`endif

  function automatic logic [2:0] enc8to3(input logic [7:0] onehot);
    logic [2:0] id;
    id = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (onehot[i]) id = id | 3'(i);
    end
    return id;
  endfunction

  // First set request at or after r_ptr, wrapping modulo 8.
  always_comb begin
    logic [2:0] idx;
    w_found = 1'b0;
    w_sel   = '0;
    idx     = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      idx = r_ptr + 3'(k);
      if (!w_found && req[idx]) begin
        w_found = 1'b1;
        w_sel   = idx;
      end
    end
  end

  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_ptr       = r_ptr;
    w_nxt_cur_id    = r_cur_id;
    w_nxt_gnt       = r_gnt;
    w_nxt_gnt_valid = r_gnt_valid;
`ifdef ARB_TIMEOUT_EN
    w_nxt_hold_cnt  = r_hold_cnt;
    w_nxt_timeout   = 1'b0;
`endif
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_nxt_state     = GRANT;
          w_nxt_cur_id    = w_sel;
          w_nxt_gnt       = 8'b1 << w_sel;
          w_nxt_gnt_valid = 1'b1;
`ifdef ARB_TIMEOUT_EN
          w_nxt_hold_cnt  = '0;
`endif
        end
      end
      GRANT: begin
        if (!req[r_cur_id]) begin
          w_nxt_state     = IDLE;
          w_nxt_gnt       = '0;
          w_nxt_gnt_valid = 1'b0;
          w_nxt_ptr       = r_cur_id + 3'd1;
        end
`ifdef ARB_TIMEOUT_EN
        // Voluntary release is checked first so it never reports a timeout.
        else if (r_hold_cnt == 8'(MAX_HOLD - 1)) begin
          w_nxt_state     = IDLE;
          w_nxt_gnt       = '0;
          w_nxt_gnt_valid = 1'b0;
          w_nxt_ptr       = r_cur_id + 3'd1;
          w_nxt_timeout   = 1'b1;
        end else begin
          w_nxt_hold_cnt  = r_hold_cnt + 8'd1;
        end
`endif
      end
      default: w_nxt_state = IDLE;
    endcase
    w_nxt_gnt_id = enc8to3(w_nxt_gnt);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_cur_id    <= '0;
      r_gnt       <= '0;
      r_gnt_id    <= '0;
      r_gnt_valid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_hold_cnt  <= '0;
      r_timeout   <= 1'b0;
`endif
    end else begin
      r_state     <= w_nxt_state;
      r_ptr       <= w_nxt_ptr;
      r_cur_id    <= w_nxt_cur_id;
      r_gnt       <= w_nxt_gnt;
      r_gnt_id    <= w_nxt_gnt_id;
      r_gnt_valid <= w_nxt_gnt_valid;
`ifdef ARB_TIMEOUT_EN
      r_hold_cnt  <= w_nxt_hold_cnt;
      r_timeout   <= w_nxt_timeout;
`endif
    end
  end

  assign gnt       = r_gnt;
  assign gnt_id    = r_gnt_id;
  assign gnt_valid = r_gnt_valid;
`ifdef ARB_TIMEOUT_EN
  assign timeout   = r_timeout;
`else
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_arb8_encoder_ctrl.sv
// Self-checking bench for arb8_encoder_ctrl: directed vector table, hand sequences,
// and randomized requests against a cycle-level behavioural model.
module tb_arb8_encoder_ctrl;

  localparam int unsigned MH = 4;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  arb8_encoder_ctrl #(.MAX_HOLD(MH)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .req      (req),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .gnt_valid(gnt_valid),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: owner < 0 means idle; m_hold counts cycles the current grant has been visible.
  int m_owner;
  int m_ptr;
  int m_hold;
  bit m_to;

  typedef struct {
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] id;
    logic       v;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_hold  = 0;
    m_to    = 0;
  endtask

  task automatic model_step(input logic [7:0] r);
    m_to = 0;
    if (m_owner < 0) begin
      for (int k = 0; k < 8; k++) begin
        if (m_owner < 0 && r[(m_ptr + k) % 8]) begin
          m_owner = (m_ptr + k) % 8;
          m_hold  = 1;
        end
      end
    end else if (!r[m_owner]) begin
      m_ptr   = (m_owner + 1) % 8;
      m_owner = -1;
    end else begin
`ifdef ARB_TIMEOUT_EN
      if (m_hold == MH) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
        m_to    = 1;
      end else begin
        m_hold++;
      end
`else
      m_hold++;
`endif
    end
  endtask

  task automatic check_model(input string tag);
    logic [7:0] eg;
    logic [7:0] eid;
    eg  = (m_owner >= 0) ? (8'b1 << m_owner) : 8'h00;
    eid = (m_owner >= 0) ? 8'(m_owner) : 8'h00;
    chk({tag, ".gnt"}, gnt, eg);
    chk({tag, ".gnt_id"}, {5'b0, gnt_id}, eid);
    chk({tag, ".gnt_valid"}, {7'b0, gnt_valid}, {7'b0, (m_owner >= 0)});
    chk({tag, ".timeout"}, {7'b0, timeout}, {7'b0, m_to});
  endtask

  task automatic cycle(input logic [7:0] r, input string tag);
    req = r;
    @(posedge clk);
    model_step(r);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    req    = 8'h00;
    resetn = 1'b0;
    #2;
    resetn = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [7:0] rq;
    logic [7:0] eg;
    logic       et;

    tbl[0]  = '{8'h04, 8'h04, 3'd2, 1'b1};
    tbl[1]  = '{8'h00, 8'h00, 3'd0, 1'b0};
    tbl[2]  = '{8'h05, 8'h01, 3'd0, 1'b1};
    tbl[3]  = '{8'h05, 8'h01, 3'd0, 1'b1};
    tbl[4]  = '{8'h04, 8'h00, 3'd0, 1'b0};
    tbl[5]  = '{8'h04, 8'h04, 3'd2, 1'b1};
    tbl[6]  = '{8'h00, 8'h00, 3'd0, 1'b0};
    tbl[7]  = '{8'h40, 8'h40, 3'd6, 1'b1};
    tbl[8]  = '{8'h00, 8'h00, 3'd0, 1'b0};
    tbl[9]  = '{8'h81, 8'h80, 3'd7, 1'b1};
    tbl[10] = '{8'h01, 8'h00, 3'd0, 1'b0};
    tbl[11] = '{8'h01, 8'h01, 3'd0, 1'b1};
    tbl[12] = '{8'h00, 8'h00, 3'd0, 1'b0};

    // Reset held with all requests asserted.
    model_reset();
    resetn = 1'b0;
    req    = 8'hFF;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("reset.gnt", gnt, 8'h00);
      chk("reset.gnt_id", {5'b0, gnt_id}, 8'h00);
      chk("reset.gnt_valid", {7'b0, gnt_valid}, 8'h00);
    end
    resetn = 1'b1;
    cycle(8'hFF, "first");
    chk("first.gnt", gnt, 8'h01);
    chk("first.gnt_id", {5'b0, gnt_id}, 8'h00);
    cycle(8'hFE, "first_rel");

    // Directed vector table from a fresh reset.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].req, "tbl_model");
      chk($sformatf("tbl[%0d].gnt", i), gnt, tbl[i].gnt);
      chk($sformatf("tbl[%0d].gnt_id", i), {5'b0, gnt_id}, {5'b0, tbl[i].id});
      chk($sformatf("tbl[%0d].gnt_valid", i), {7'b0, gnt_valid}, {7'b0, tbl[i].v});
    end

    // Fairness: every requester is served in order 0..7 then 0 again.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cycle(8'hFF, "fair_grant");
      chk("fair.gnt_id", {5'b0, gnt_id}, 8'(i % 8));
      chk("fair.gnt_valid", {7'b0, gnt_valid}, 8'h01);
      cycle(8'hFF & ~(8'b1 << (i % 8)), "fair_gap");
      chk("fair.gap_valid", {7'b0, gnt_valid}, 8'h00);
    end

    // Long hold of requester 5.
    for (int c = 1; c <= 6; c++) begin
      cycle(8'h20, "hold");
`ifdef ARB_TIMEOUT_EN
      eg = (c == 5) ? 8'h00 : 8'h20;
      et = (c == 5);
`else
      eg = 8'h20;
      et = 1'b0;
`endif
      chk($sformatf("hold[%0d].gnt", c), gnt, eg);
      chk($sformatf("hold[%0d].timeout", c), {7'b0, timeout}, {7'b0, et});
    end
    cycle(8'h00, "hold_rel");

    // Asynchronous reset in the middle of a grant.
    cycle(8'h10, "mid_grant");
    cycle(8'h10, "mid_hold");
    chk("mid.gnt_before", gnt, 8'h10);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid.gnt_async", gnt, 8'h00);
    chk("mid.gnt_id_async", {5'b0, gnt_id}, 8'h00);
    chk("mid.valid_async", {7'b0, gnt_valid}, 8'h00);
    model_reset();
    #1;
    resetn = 1'b1;
    cycle(8'hFF, "post_reset");
    chk("post_reset.gnt", gnt, 8'h01);
    cycle(8'h00, "post_reset_rel");

    // Randomized traffic against the model.
    do_reset();
    rq = 8'h00;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) rq = 8'($urandom);
      if ($urandom_range(0, 5) == 0 && m_owner >= 0) rq[m_owner] = 1'b0;
      cycle(rq, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arb8_encoder_ctrl.md
# arb8_encoder_ctrl

- Round-robin arbiter and grant sequencer for eight requesters sharing one downstream resource.
- Requester identity is reported as a one-hot grant and as the equivalent 3-bit index, produced by the team's 8-to-3 encoder datapath.
- Sits between the request sources and the shared resource; owns fairness, grant hold and release sequencing.

## Interface
Parameters:
- MAX_HOLD, 16, maximum consecutive grant cycles for one requester (range 2..255); used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  input  1  single clock; all state on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- req  input  8  request lines; bit i = requester i; level-sensitive.
- gnt  output  8  one-hot grant; at most one bit set.
- gnt_id  output  3  binary index of the granted requester; 0 when gnt_valid=0.
- gnt_valid  output  1  high while any grant is held.
- timeout  output  1  one-cycle pulse on a forced release; constant 0 without ARB_TIMEOUT_EN.

## Operation
- State machine: IDLE, GRANT.
- Registered state: state, ptr[2:0] (highest-priority index), cur_id[2:0], hold_cnt (only with ARB_TIMEOUT_EN).
- IDLE:
  - req==0: stay in IDLE.
  - Otherwise select the first set bit of req scanning ptr, ptr+1, …, ptr+7 (mod 8).
  - Set gnt to that one-hot, gnt_id to its index, gnt_valid=1; go to GRANT.
- GRANT:
  - req[cur_id]==1: hold the grant; other request changes are ignored.
  - req[cur_id]==0: clear gnt, gnt_id, gnt_valid; ptr <= cur_id+1 (3-bit wrap, 7->0); go to IDLE.
- No re-arbitration happens directly from GRANT. There is always at least one cycle with gnt_valid=0 between two grants.
- gnt_id is the encoded form of gnt. The invariant gnt == (gnt_valid ? 1<<gnt_id : 0) holds every cycle.
- Requests that drop while not granted are not latched.

## Timing
- Reset values: gnt=0, gnt_id=0, gnt_valid=0, timeout=0, ptr=0, hold_cnt=0, state=IDLE.
- Reset asserted mid-grant clears all state immediately, without waiting for a clock edge.
- Grant latency: req sampled high at edge N -> gnt visible after edge N (one cycle from the request being set up).
- Release latency: req[cur_id] sampled low at edge M -> gnt=0 after edge M.
  - With other requests still pending, the next grant appears after edge M+1.
- All outputs are registered; there are no combinational paths from req to the outputs.

## Configuration
- ARB_TIMEOUT_EN defined:
  - hold_cnt clears on entry to GRANT and increments each GRANT cycle.
  - When hold_cnt reaches MAX_HOLD-1 with req[cur_id] still high, the next edge forces a release: gnt cleared, ptr <= cur_id+1, timeout=1 for one cycle, state to IDLE.
  - The grant therefore lasts exactly MAX_HOLD cycles.
  - A still-asserted request is re-arbitrated normally afterwards.
  - A voluntary release on the same edge as the timeout counts as voluntary: timeout stays 0.
- ARB_TIMEOUT_EN undefined: no hold_cnt; grants are held indefinitely; timeout tied to 0.

## Test plan
- Reset: resetn=0 with req=8'hFF -> gnt=0, gnt_id=0, gnt_valid=0 for the whole reset period; after release, the first grant is gnt=8'h01, gnt_id=0.
- Single requester: req=8'h04 -> next cycle gnt=8'h04, gnt_id=2; drop req -> gnt=0 next cycle, then req=8'h05 -> gnt=8'h01 (ptr=3 wraps to 0).
- Fairness: req=8'hFF, each requester drops its bit one cycle after being granted and reasserts it -> gnt_id sequence 0,1,2,…,7,0 with one idle cycle between grants.
- Wrap: requester 6 is granted then released (ptr=7); req=8'h81 -> grant 7 first, then 0.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4): req=8'h20 held -> gnt=8'h20 for exactly 4 cycles, timeout pulses once, gnt=0 for 1 cycle, regrant 8'h20; without the macro gnt stays 8'h20 and timeout stays 0.
- Reset mid-grant: gnt=8'h10 held, resetn low between edges -> outputs 0 immediately; after release with req=8'hFF -> grant 0 (ptr reset to 0).
